reg_alu_sequencer: RTL
======================

# reg_alu_sequencer

Multi-cycle operation sequencer placed directly upstream of the 4×16-bit register file. It accepts one instruction at a time over a valid/ready handshake and fetches operands through the register file's single read port, one operand per cycle. It computes a 16-bit result and writes it back through the register file's write port. It also keeps registered zero and carry flags for downstream control logic.

## Interface
- No parameters; data width fixed at 16, register index width fixed at 2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  sequencer can accept an instruction this cycle.
- `instr_op`  in  3  0 LOADI, 1 MOV, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 ADDI.
- `instr_dst`  in  2  destination register index.
- `instr_src_a`  in  2  first source register index.
- `instr_src_b`  in  2  second source register index; used by ops 2–6 only.
- `instr_imm`  in  16  immediate; used by LOADI and ADDI only.
- `read_index_a`  out  2  to register file read index.
- `read_data_a`  in  16  from register file; combinational, valid in the same cycle as `read_index_a`.
- `write_index`  out  2  to register file write index.
- `write_enable`  out  1  to register file write enable.
- `write_data`  out  16  to register file write data.
- `done`  out  1  one-cycle pulse, coincident with the write-back cycle.
- `zero_flag`  out  1  registered; result of the last completed instruction was 0.
- `carry_flag`  out  1  registered; carry/borrow of the last completed instruction.

## Operation
- States: IDLE, RD_A, RD_B, WB.
- Acceptance: a handshake occurs when `instr_valid && instr_ready` at a rising edge. On acceptance, latch op, dst, src_a, src_b and imm.
- IDLE → WB for LOADI, which captures result = imm at acceptance.
- IDLE → RD_A for all other ops.
- RD_A: drive `read_index_a` = src_a.
  - MOV captures result = read_data_a and goes to WB.
  - ADDI captures result = read_data_a + imm and goes to WB.
  - Ops 2–6 latch op_a = read_data_a and go to RD_B.
- RD_B: drive `read_index_a` = src_b and capture result = op_a ⊕ read_data_a, where ⊕ is ADD (a+b), SUB (a−b), AND, OR or XOR. Then go to WB.
- WB: `write_enable`=1, `write_index`=dst, `write_data`=result, `done`=1. Flags update at the end of this cycle. Next state is IDLE.
- Arithmetic is 16-bit modulo 2^16.
  - ADD/ADDI: carry = bit 16 of the 17-bit sum.
  - SUB: carry = 1 iff a < b, unsigned borrow.
  - LOADI, MOV and logic ops: carry = 0.
- zero_flag = (result == 16'h0000).
- `instr_ready` = (state == IDLE) && !reset. It is held low in all other states; the upstream source must hold the instruction stable until accepted.
- `read_index_a` = 0 outside RD_A/RD_B.
- src_a == src_b and dst == src are legal. Operand reads complete before the write-back of the same instruction.

## Timing
- Reset values: state IDLE; `instr_ready` 0 while reset is high and 1 the first cycle after it drops; `write_enable`, `done`, `write_index`, `write_data`, `read_index_a`, `zero_flag`, `carry_flag` all 0; internal latches cleared.
- Reset mid-operation: the instruction is aborted on the next edge, no write-back occurs, and flags are cleared. This includes reset asserted during WB: `write_enable` is already high that cycle, so the register file's own reset takes precedence.
- Latency, with acceptance at edge T (state leaves IDLE after T):
  - LOADI: WB is the cycle after T (1 cycle).
  - MOV/ADDI: 2 cycles.
  - Ops 2–6: 3 cycles.
- The next acceptance is possible at the edge ending the first IDLE cycle after WB. Peak throughput: one LOADI per 2 cycles, one two-operand op per 4 cycles.
- Back-to-back dependency: a write from WB is visible in the register file by the next instruction's RD_A. No forwarding is required.
- `instr_valid` without `instr_ready` causes no state change.

## Test plan
The bench uses a behavioural register-file model in which read index i returns the value last written at index i.
- Reset, then LOADI r1,16'h1234 → `write_enable` 1 cycle after acceptance with index 1, data 16'h1234, `done`=1, zero=0, carry=0.
- LOADI r0,16'hFFFF; LOADI r2,16'h0001; ADD r3,r0,r2 → write r3=16'h0000, zero=1, carry=1, 3 cycles after ADD acceptance.
- SUB r1,r2,r0 with r2=5 and r0=7 → r1=16'hFFFE, carry=1, zero=0. Then XOR r1,r1,r1 → r1=0, zero=1, carry=0.
- ADDI r2,r2,16'h0010 from r2=16'h00F0 → r2=16'h0100 two cycles after acceptance. Then MOV r0,r2 → r0=16'h0100. This checks the dependent back-to-back write-visibility path.
- Hold `instr_valid`=1 continuously with an AND instruction → `instr_ready` low in RD_A/RD_B/WB and exactly one write per 4 cycles. Also checks AND r3,r0,r2 with 16'hF0F0 & 16'h0FF0 = 16'h00F0.
- Assert reset during RD_B of an ADD → no `write_enable`, flags 0, `instr_ready` 0 during reset, then 1 on the following cycle.

Source files
------------

// File: rtl/reg_alu_sequencer.sv
// Multi-cycle instruction sequencer in front of a 4x16 register file: fetches
// operands through one read port, computes a 16-bit result, writes it back.
module reg_alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [2:0]  instr_op,
  input  logic [1:0]  instr_dst,
  input  logic [1:0]  instr_src_a,
  input  logic [1:0]  instr_src_b,
  input  logic [15:0] instr_imm,
  output logic [1:0]  read_index_a,
  input  logic [15:0] read_data_a,
  output logic [1:0]  write_index,
  output logic        write_enable,
  output logic [15:0] write_data,
  output logic        done,
  output logic        zero_flag,
  output logic        carry_flag
);

  localparam logic [2:0] OP_LOADI = 3'd0;
  localparam logic [2:0] OP_MOV   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_AND   = 3'd4;
  localparam logic [2:0] OP_OR    = 3'd5;
  localparam logic [2:0] OP_XOR   = 3'd6;
  localparam logic [2:0] OP_ADDI  = 3'd7;

  typedef enum logic [1:0] {IDLE, RD_A, RD_B, WB} state_t;

  state_t      state_reg;
  logic [2:0]  op_reg;
  logic [1:0]  dst_reg;
  logic [1:0]  src_b_reg;
  logic [15:0] imm_reg;
  logic [15:0] op_a_reg;
  logic        carry_reg;
  logic [1:0]  read_index_reg;
  logic [1:0]  write_index_reg;
  logic        write_enable_reg;
  logic [15:0] write_data_reg;
  logic        done_reg;
  logic        zero_flag_reg;
  logic        carry_flag_reg;

  logic [16:0] sum_a_imm;
  logic [16:0] sum_ab;
  logic [16:0] diff_ab;
  logic [15:0] alu_result;
  logic        alu_carry;
  logic        go_wb;

  assign sum_a_imm = {1'b0, read_data_a} + {1'b0, imm_reg};
  assign sum_ab    = {1'b0, op_a_reg} + {1'b0, read_data_a};
  // Bit 16 of the 17-bit difference is the unsigned borrow (a < b).
  assign diff_ab   = {1'b0, op_a_reg} - {1'b0, read_data_a};

  // Result and carry for whichever state is about to hand off to write-back.
  always_comb begin
    alu_result = 16'h0000;
    alu_carry  = 1'b0;
    go_wb      = 1'b0;
    case (state_reg)
      IDLE: begin
        alu_result = instr_imm;
        go_wb      = instr_valid && (instr_op == OP_LOADI);
      end
      RD_A: begin
        case (op_reg)
          OP_MOV: begin
            alu_result = read_data_a;
            go_wb      = 1'b1;
          end
          OP_ADDI: begin
            alu_result = sum_a_imm[15:0];
            alu_carry  = sum_a_imm[16];
            go_wb      = 1'b1;
          end
          default: ;
        endcase
      end
      RD_B: begin
        go_wb = 1'b1;
        case (op_reg)
          OP_ADD: begin
            alu_result = sum_ab[15:0];
            alu_carry  = sum_ab[16];
          end
          OP_SUB: begin
            alu_result = diff_ab[15:0];
            alu_carry  = diff_ab[16];
          end
          OP_AND:  alu_result = op_a_reg & read_data_a;
          OP_OR:   alu_result = op_a_reg | read_data_a;
          OP_XOR:  alu_result = op_a_reg ^ read_data_a;
          default: alu_result = 16'h0000;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      op_reg           <= 3'd0;
      dst_reg          <= 2'd0;
      src_b_reg        <= 2'd0;
      imm_reg          <= 16'h0000;
      op_a_reg         <= 16'h0000;
      carry_reg        <= 1'b0;
      read_index_reg   <= 2'd0;
      write_index_reg  <= 2'd0;
      write_enable_reg <= 1'b0;
      write_data_reg   <= 16'h0000;
      done_reg         <= 1'b0;
      zero_flag_reg    <= 1'b0;
      carry_flag_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (instr_valid) begin
            op_reg    <= instr_op;
            dst_reg   <= instr_dst;
            src_b_reg <= instr_src_b;
            imm_reg   <= instr_imm;
            if (instr_op != OP_LOADI) begin
              state_reg      <= RD_A;
              read_index_reg <= instr_src_a;
            end
          end
        end
        RD_A: begin
          if (!go_wb) begin
            op_a_reg       <= read_data_a;
            read_index_reg <= src_b_reg;
            state_reg      <= RD_B;
          end
        end
        WB: begin
          state_reg        <= IDLE;
          write_enable_reg <= 1'b0;
          done_reg         <= 1'b0;
          write_index_reg  <= 2'd0;
          write_data_reg   <= 16'h0000;
          zero_flag_reg    <= (write_data_reg == 16'h0000);
          carry_flag_reg   <= carry_reg;
        end
        default: ;
      endcase

      // Outputs are loaded on entry to WB so they are valid for the whole cycle.
      if (go_wb) begin
        state_reg        <= WB;
        write_enable_reg <= 1'b1;
        done_reg         <= 1'b1;
        write_index_reg  <= (state_reg == IDLE) ? instr_dst : dst_reg;
        write_data_reg   <= alu_result;
        carry_reg        <= alu_carry;
        read_index_reg   <= 2'd0;
      end
    end
  end

  assign instr_ready  = (state_reg == IDLE) && !reset;
  assign read_index_a = read_index_reg;
  assign write_index  = write_index_reg;
  assign write_enable = write_enable_reg;
  assign write_data   = write_data_reg;
  assign done         = done_reg;
  assign zero_flag    = zero_flag_reg;
  assign carry_flag   = carry_flag_reg;

endmodule
